sensor_phase_ctrl: RTL
======================

# sensor_phase_ctrl

Closed-loop phase controller for the two image sensors in the HDR capture path. It measures the frame-start offset between sensor channel 0 and channel 1 on their vsync outputs. It then drives the `err_ch0`/`err_ch1` request levels of the 24 MHz sensor-clock generator so that the lagging sensor's clock is sped up until both frames start together. It also reports lock status and the measured offset to the control CPU.

## Interface
Parameters:
- `CNT_W`, 24, width of the offset counter and of `offset`.
- `TOL`, 64, maximum offset in clk cycles that counts as aligned; corrections start above this value.
- `REL`, 32, release threshold for an active correction (hysteresis); must be ≤ `TOL`.
- `LOCK_FRAMES`, 4, number of consecutive in-tolerance measurements required before `locked` asserts.

Ports:
- `clk`  in  1  system clock (240 MHz domain, same as the clock generator).
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  control enable, synchronous to clk.
- `vsync_0`  in  1  channel 0 vsync, asynchronous to clk.
- `vsync_1`  in  1  channel 1 vsync, asynchronous to clk.
- `err_ch0`  out  1  request to speed up the channel 0 sensor clock (level).
- `err_ch1`  out  1  request to speed up the channel 1 sensor clock (level).
- `locked`  out  1  alignment achieved.
- `lead_ch`  out  1  leading channel of the last measurement (0 or 1).
- `offset`  out  CNT_W  last measured offset in clk cycles.
- `offset_valid`  out  1  one-cycle strobe when `offset` updates.

## Operation
- Each vsync passes through a 2-FF synchronizer followed by rising-edge detection, producing a 1-cycle pulse (`r0`, `r1`).

FSM states: IDLE, WAIT_FIRST, MEASURE, EVALUATE.
- **IDLE**
  - `err_ch0`, `err_ch1`, `locked`, the lock counter and the correcting flag are all 0.
  - Moves to WAIT_FIRST when `enable`=1.
- **WAIT_FIRST**
  - `r0` and `r1` in the same cycle: capture `offset`=0 and `lead_ch`=0, then go to EVALUATE.
  - A single pulse: set `lead_ch` to the pulsing channel and `cnt`=1, then go to MEASURE.
- **MEASURE**
  - `cnt` increments by 1 per cycle and saturates at all-ones.
  - Pulse on the lagging channel: capture `offset`=`cnt`, then go to EVALUATE. The two-pulse case (lead and lag in the same cycle) also takes this path.
  - Pulse on the leading channel alone (lagging frame missed): restart with `cnt`=1, clear the lock counter and `locked`. `offset_valid` does not pulse.
  - `cnt` reaches all-ones: go to WAIT_FIRST, clear the lock counter and `locked`.
- **EVALUATE** (one cycle)
  - `offset_valid`=1.
  - Threshold: `REL` if a correction is active in the same direction, otherwise `TOL`.
  - Offset ≤ threshold:
    - Clear both err outputs and the correcting flag.
    - Increment the lock counter, saturating at `LOCK_FRAMES`.
    - `locked`=1 when the counter equals `LOCK_FRAMES`.
  - Offset > threshold:
    - Clear the lock counter and `locked`.
    - Set the correcting flag and assert err for the lagging channel (`err_ch1` if `lead_ch`=0, else `err_ch0`).
    - If the active correction is in the opposite direction, drop it in this evaluation; the new direction asserts no earlier than the next EVALUATE.
  - Always returns to WAIT_FIRST.
- `err_ch0` and `err_ch1` are never 1 simultaneously.
- Err outputs change only in EVALUATE or on leaving to IDLE. They are held as levels between evaluations.
- `enable`=0 in any state: go to IDLE on the next edge and clear all outputs except `offset` and `lead_ch`.

## Timing
- Reset values: all outputs 0; state IDLE.
- Latency from a vsync pin edge to the r pulse is 3 clk cycles (2 synchronizer stages plus edge register). This latency is equal on both channels, so `offset` equals the pin-level skew ±1 cycle.
- `offset_valid`, `offset`, the err outputs and `locked` all update on the clock edge after the lagging r pulse.
- Offset is measured from whichever channel pulses first after WAIT_FIRST. Speeding the lagging clock always converges, because the offset shrinks modulo the frame period.
- `reset_n` or `enable` deasserted mid-measurement aborts the measurement with no `offset_valid`.

## Structure
- Package `sensor_phase_pkg` holds:
  - the state enum (3-bit);
  - channel id constants `CH0`=0 and `CH1`=1.
- Sub-module `vsync_edge_sync`: 2-FF synchronizer plus rising-edge detector, async active-low reset, instantiated once per channel.

## Test plan
All scenarios use the default parameters unless stated.
- **Aligned frames:** `vsync_0`/`vsync_1` rise in the same cycle every frame → each frame gives `offset`=0 and an `offset_valid` pulse; `locked`=1 after the 4th frame; err outputs stay 0.
- **Lagging channel 1:** `vsync_1` lags by 200 cycles → `offset`=200 (±1), `lead_ch`=0, `err_ch1`=1, `err_ch0`=0, `locked`=0.
- **Hysteresis:** while correcting ch1, a lag of 50 keeps `err_ch1`=1; a lag of 30 drops `err_ch1`; 4 further aligned frames give `locked`=1.
- **Missing lagging frame:** two `vsync_0` rises with no `vsync_1` rise → restart with no `offset_valid` and `locked`=0.
- **Counter saturation:** with `CNT_W`=8 and no lagging edge, the block returns to WAIT_FIRST after 255 cycles.
- **Direction switch:** ch1 lagging and correcting, then ch0 lagging by 300 → at the first EVALUATE both err outputs are 0, at the next `err_ch0`=1; the two err outputs are never high together.
- **Abort mid-operation:** deasserting `enable` during a correction drives `err_ch1`, `locked` and `offset_valid` to 0 on the next edge and the FSM to IDLE; asserting `reset_n` low in MEASURE clears all outputs immediately.

Source files
------------

// File: rtl/sensor_phase_pkg.sv
// Shared types and constants for the dual-sensor vsync phase controller.
package sensor_phase_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FIRST = 3'd1,
        MEASURE    = 3'd2,
        EVALUATE   = 3'd3
    } state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/vsync_edge_sync.sv
// Two-flop synchronizer for an asynchronous vsync pin followed by a registered
// rising-edge detector; pin edge to pulse is three clk cycles.
module vsync_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic vsync,
    output logic pulse
);

    logic sync_ff1;
    logic sync_ff2;
    logic sync_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff1  <= 1'b0;
            sync_ff2  <= 1'b0;
            sync_prev <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            sync_ff1  <= vsync;
            sync_ff2  <= sync_ff1;
            sync_prev <= sync_ff2;
            pulse     <= sync_ff2 & ~sync_prev;
        end
    end

endmodule

// File: rtl/sensor_phase_ctrl.sv
// Measures frame-start skew between two sensors and requests a speed-up of the
// lagging sensor clock until both vsyncs align; reports lock and offset.
module sensor_phase_ctrl
    import sensor_phase_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int TOL         = 64,
    parameter int REL         = 32,
    parameter int LOCK_FRAMES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             vsync_0,
    input  logic             vsync_1,
    output logic             err_ch0,
    output logic             err_ch1,
    output logic             locked,
    output logic             lead_ch,
    output logic [CNT_W-1:0] offset,
    output logic             offset_valid,
    output state_t           fsm_state
);

    localparam int               LW       = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] REL_C    = CNT_W'(REL);
    localparam logic [LW-1:0]    LOCK_MAX = LW'(LOCK_FRAMES);

    state_t           state;
    state_t           state_next;
    logic             r0;
    logic             r1;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] offset_d;
    logic             lead_d;
    logic [LW-1:0]    lock_cnt;
    logic [LW-1:0]    lock_cnt_d;
    logic             correcting;
    logic             correcting_d;
    logic             corr_dir;
    logic             corr_dir_d;
    logic             err0_d;
    logic             err1_d;
    logic             locked_d;
    logic             valid_d;
    logic             lag_pulse;
    logic             lead_pulse;
    logic             go_eval;
    logic [CNT_W-1:0] meas_off;
    logic             meas_lag;
    logic [CNT_W-1:0] thr;

    vsync_edge_sync u_sync_0 (.clk(clk), .reset_n(reset_n), .vsync(vsync_0), .pulse(r0));
    vsync_edge_sync u_sync_1 (.clk(clk), .reset_n(reset_n), .vsync(vsync_1), .pulse(r1));

    assign fsm_state  = state;
    assign lag_pulse  = (lead_ch == CH0) ? r1 : r0;
    assign lead_pulse = (lead_ch == CH0) ? r0 : r1;
    assign go_eval    = enable && (((state == WAIT_FIRST) && r0 && r1) ||
                                   ((state == MEASURE) && lag_pulse));
    // A simultaneous pair in WAIT_FIRST is a zero-offset measurement led by ch0.
    assign meas_off   = (state == MEASURE) ? cnt : '0;
    assign meas_lag   = (state == MEASURE) ? ~lead_ch : CH1;
    // Tighter release threshold only while the same channel is already being sped up.
    assign thr        = (correcting && (corr_dir == meas_lag)) ? REL_C : TOL_C;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:       state_next = WAIT_FIRST;
                WAIT_FIRST: begin
                    if (r0 && r1)      state_next = EVALUATE;
                    else if (r0 || r1) state_next = MEASURE;
                end
                MEASURE: begin
                    if (lag_pulse)           state_next = EVALUATE;
                    else if (lead_pulse)     state_next = MEASURE;
                    else if (cnt == CNT_MAX) state_next = WAIT_FIRST;
                end
                EVALUATE:   state_next = WAIT_FIRST;
                default:    state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d        = cnt;
        offset_d     = offset;
        lead_d       = lead_ch;
        lock_cnt_d   = lock_cnt;
        correcting_d = correcting;
        corr_dir_d   = corr_dir;
        err0_d       = err_ch0;
        err1_d       = err_ch1;
        locked_d     = locked;
        valid_d      = 1'b0;
        if (!enable || state == IDLE) begin
            err0_d       = 1'b0;
            err1_d       = 1'b0;
            locked_d     = 1'b0;
            lock_cnt_d   = '0;
            correcting_d = 1'b0;
        end else begin
            case (state)
                WAIT_FIRST: begin
                    if (r0 ^ r1) begin
                        lead_d = r1 ? CH1 : CH0;
                        cnt_d  = CNT_ONE;
                    end
                end
                MEASURE: begin
                    if (!lag_pulse) begin
                        if (lead_pulse) begin
                            cnt_d      = CNT_ONE;
                            lock_cnt_d = '0;
                            locked_d   = 1'b0;
                        end else if (cnt == CNT_MAX) begin
                            lock_cnt_d = '0;
                            locked_d   = 1'b0;
                        end else begin
                            cnt_d = cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (go_eval) begin
                valid_d  = 1'b1;
                offset_d = meas_off;
                lead_d   = ~meas_lag;
                if (meas_off <= thr) begin
                    err0_d       = 1'b0;
                    err1_d       = 1'b0;
                    correcting_d = 1'b0;
                    if (lock_cnt != LOCK_MAX) lock_cnt_d = lock_cnt + 1'b1;
                    locked_d = (lock_cnt_d == LOCK_MAX);
                end else begin
                    lock_cnt_d = '0;
                    locked_d   = 1'b0;
                    if (correcting && (corr_dir != meas_lag)) begin
                        // Direction flip: release first, the new side asserts next frame.
                        err0_d       = 1'b0;
                        err1_d       = 1'b0;
                        correcting_d = 1'b0;
                    end else begin
                        correcting_d = 1'b1;
                        corr_dir_d   = meas_lag;
                        err0_d       = (meas_lag == CH0);
                        err1_d       = (meas_lag == CH1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            offset       <= '0;
            lead_ch      <= CH0;
            lock_cnt     <= '0;
            correcting   <= 1'b0;
            corr_dir     <= CH0;
            err_ch0      <= 1'b0;
            err_ch1      <= 1'b0;
            locked       <= 1'b0;
            offset_valid <= 1'b0;
        end else begin
            cnt          <= cnt_d;
            offset       <= offset_d;
            lead_ch      <= lead_d;
            lock_cnt     <= lock_cnt_d;
            correcting   <= correcting_d;
            corr_dir     <= corr_dir_d;
            err_ch0      <= err0_d;
            err_ch1      <= err1_d;
            locked       <= locked_d;
            offset_valid <= valid_d;
        end
    end

endmodule
